// File: rtl/turf_wb_cmd_initiator.sv
// Wishbone classic initiator: one bus transaction per accepted command, with
// per-attempt timeout, bounded RTY reissue and a registered response stream.
//
// state  | meaning
// IDLE   | cmd_ready_o high, waiting for a command
// BUS    | cyc/stb asserted (or one-cycle gap before a retry reissue)
// RESP   | rsp_valid_o high, holding data/status until rsp_ready_i
module turf_wb_cmd_initiator #(
  parameter int NUM_ADDRESS_BITS = 15,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int MAX_RETRIES      = 3
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [NUM_ADDRESS_BITS-1:0] cmd_adr_i,
  input  logic [31:0]                 cmd_dat_i,
  input  logic                        cmd_we_i,
  input  logic [3:0]                  cmd_sel_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [31:0]                 rsp_dat_o,
  output logic [1:0]                  rsp_status_o,
  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  output logic                        wb_we_o,
  output logic [NUM_ADDRESS_BITS-1:0] wb_adr_o,
  output logic [31:0]                 wb_dat_o,
  output logic [3:0]                  wb_sel_o,
  input  logic [31:0]                 wb_dat_i,
  input  logic                        wb_ack_i,
  input  logic                        wb_err_i,
  input  logic                        wb_rty_i,
  output logic                        timeout_o,
  output logic                        invalid_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [1:0] ST_RTY = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t                      state_q, state_d;
  logic                        gap_q, gap_d;
  logic [TW-1:0]               tmo_cnt_q, tmo_cnt_d;
  logic [RW-1:0]               rty_cnt_q, rty_cnt_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        cyc_q, cyc_d;
  logic                        we_q, we_d;
  logic [NUM_ADDRESS_BITS-1:0] adr_q, adr_d;
  logic [31:0]                 dat_q, dat_d;
  logic [3:0]                  sel_q, sel_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [31:0]                 rsp_dat_q, rsp_dat_d;
  logic [1:0]                  rsp_status_q, rsp_status_d;
  logic                        timeout_q, timeout_d;
  logic                        invalid_q, invalid_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      gap_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      rty_cnt_q    <= '0;
      cmd_ready_q  <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
      timeout_q    <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rty_cnt_q    <= rty_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      timeout_q    <= timeout_d;
      invalid_q    <= invalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    tmo_cnt_d    = tmo_cnt_q;
    rty_cnt_d    = rty_cnt_q;
    cmd_ready_d  = cmd_ready_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    timeout_d    = 1'b0;
    invalid_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Ready is registered so it stays low for the first cycle after reset.
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && cmd_valid_i) begin
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          sel_d       = cmd_sel_i;
          tmo_cnt_d   = '0;
          rty_cnt_d   = '0;
          gap_d       = 1'b0;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = S_BUS;
        end
      end

      S_BUS: begin
        if (gap_q) begin
          // Retry gap: bus idle for this one cycle, terminations not sampled.
          gap_d = 1'b0;
          cyc_d = 1'b1;
        end else if (wb_ack_i) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_dat_d    = we_q ? 32'h0 : wb_dat_i;
          rsp_status_d = ST_OK;
          state_d      = S_RESP;
        end else if (wb_err_i) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_dat_d    = 32'h0;
          rsp_status_d = ST_ERR;
          invalid_d    = 1'b1;
          state_d      = S_RESP;
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          if (rty_cnt_q < RTY_MAX) begin
            rty_cnt_d = rty_cnt_q + RW'(1);
            tmo_cnt_d = '0;
            gap_d     = 1'b1;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_dat_d    = 32'h0;
            rsp_status_d = ST_RTY;
            invalid_d    = 1'b1;
            state_d      = S_RESP;
          end
        end else if (tmo_cnt_q >= TMO_LAST) begin
          // This is the TIMEOUT_CYCLES-th unterminated cycle: abort now.
          cyc_d        = 1'b0;
          tmo_cnt_d    = TMO_MAX;
          rsp_valid_d  = 1'b1;
          rsp_dat_d    = 32'h0;
          rsp_status_d = ST_TMO;
          timeout_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d  = 1'b0;
          rsp_dat_d    = 32'h0;
          rsp_status_d = ST_OK;
          cmd_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign timeout_o    = timeout_q;
  assign invalid_o    = invalid_q;

endmodule

// File: tb/tb_turf_wb_cmd_initiator.sv
// Bench for turf_wb_cmd_initiator: table of commands with a scripted Wishbone
// target, a response scoreboard, and hand-written reset / stray-termination cases.
module tb_turf_wb_cmd_initiator;

  localparam int AW   = 15;
  localparam int TMO  = 255;
  localparam int MAXR = 3;

  localparam int T_ACK    = 0;
  localparam int T_ERR    = 1;
  localparam int T_ACKERR = 2;
  localparam int T_NONE   = 3;

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    int            delay;
    int            n_rty;
    int            fin;
    logic [31:0]   rdata;
    int            hold;
    int            exp_issues;
    logic [1:0]    exp_status;
    logic [31:0]   exp_dat;
    bit            exp_tmo;
    bit            exp_inv;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  status;
  } rsp_t;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [31:0]   cmd_dat_i = '0;
  logic          cmd_we_i = 1'b0;
  logic [3:0]    cmd_sel_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_dat_o;
  logic [1:0]    rsp_status_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;
  logic          wb_rty_i = 1'b0;
  logic          timeout_o, invalid_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t sb_q[$];
  vec_t vecs[11];

  always #5 wb_clk_i = ~wb_clk_i;

  turf_wb_cmd_initiator #(
    .NUM_ADDRESS_BITS(AW),
    .TIMEOUT_CYCLES  (TMO),
    .MAX_RETRIES     (MAXR)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_we_i    (cmd_we_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .wb_rty_i    (wb_rty_i),
    .timeout_o   (timeout_o),
    .invalid_o   (invalid_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge wb_clk_i);
    end
    if (!ok) check({tag, "_ready_wait"}, 32'd0, 32'd1);
  endtask

  // Handshake one command; returns at the negedge after acceptance.
  task automatic drive_cmd(input string tag, input bit we, input logic [AW-1:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, output bit ok);
    wait_ready(tag, ok);
    if (ok) begin
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      cmd_sel_i   = sel;
      @(negedge wb_clk_i);
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   issues, hi, lo, tmo_seen, inv_seen, exp_hi;
    bit   prev_cyc, got, ok;
    rsp_t e, exp_r;
    issues = 0; hi = 0; lo = 0; tmo_seen = 0; inv_seen = 0;
    prev_cyc = 1'b0; got = 1'b0;
    wb_dat_i = v.rdata;
    exp_r.dat = v.exp_dat;
    exp_r.status = v.exp_status;
    sb_q.push_back(exp_r);
    drive_cmd(tag, v.we, v.adr, v.dat, v.sel, ok);
    if (!ok) begin
      void'(sb_q.pop_back());
      return;
    end
    for (int c = 0; c < 2000; c++) begin
      if (timeout_o) tmo_seen++;
      if (invalid_o) inv_seen++;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (wb_cyc_o) begin
        if (!prev_cyc) begin
          issues++;
          hi = 0;
          if (issues > 1) check({tag, "_gap_cycles"}, lo, 1);
          check({tag, "_adr"}, 32'(wb_adr_o), 32'(v.adr));
          check({tag, "_we_sel_stb"}, {wb_we_o, wb_sel_o, wb_stb_o, cmd_ready_o},
                {v.we, v.sel, 1'b1, 1'b0});
          if (v.we) check({tag, "_wdat"}, wb_dat_o, v.dat);
        end
        hi++;
        if (hi == v.delay + 1) begin
          if (issues <= v.n_rty) wb_rty_i = 1'b1;
          else if (v.fin == T_ACK) wb_ack_i = 1'b1;
          else if (v.fin == T_ERR) wb_err_i = 1'b1;
          else if (v.fin == T_ACKERR) begin
            wb_ack_i = 1'b1;
            wb_err_i = 1'b1;
          end
        end
      end else begin
        if (prev_cyc) begin
          exp_hi = (issues <= v.n_rty || v.fin != T_NONE) ? v.delay + 1 : TMO;
          check({tag, "_hi_cycles"}, hi, exp_hi);
          lo = 0;
        end
        lo++;
        if (rsp_valid_o) begin
          got = 1'b1;
          break;
        end
      end
      prev_cyc = wb_cyc_o;
      @(negedge wb_clk_i);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    if (!got) begin
      check({tag, "_rsp_wait"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_issues"}, issues, v.exp_issues);
    check({tag, "_pulse_align"}, {timeout_o, invalid_o}, {v.exp_tmo, v.exp_inv});
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_rsp_dat"}, rsp_dat_o, e.dat);
    check({tag, "_rsp_status"}, rsp_status_o, e.status);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge wb_clk_i);
      if (timeout_o) tmo_seen++;
      if (invalid_o) inv_seen++;
    end
    check({tag, "_hold"}, {rsp_valid_o, rsp_status_o, rsp_dat_o}, {1'b1, e.status, e.dat});
    check({tag, "_tmo_count"}, tmo_seen, v.exp_tmo);
    check({tag, "_inv_count"}, inv_seen, v.exp_inv);
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    check({tag, "_after_rsp"}, {rsp_valid_o, cmd_ready_o}, 2'b01);
  endtask

  initial begin
    bit ok;
    // we adr dat sel delay n_rty fin rdata hold | issues status dat tmo inv
    vecs[0]  = '{1'b0, 15'h0100, 32'h0, 4'hF, 2, 0, T_ACK, 32'h54555246, 0,
                 1, 2'b00, 32'h54555246, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 15'h000C, 32'h1, 4'h1, 1, 0, T_ACK, 32'hFFFFFFFF, 1,
                 1, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 15'h7FFC, 32'h0, 4'h3, 0, 0, T_ACK, 32'hA5A50001, 2,
                 1, 2'b00, 32'hA5A50001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 15'h0040, 32'h0, 4'hF, 0, 0, T_NONE, 32'h12345678, 2,
                 1, 2'b10, 32'h0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 15'h0044, 32'h0, 4'hF, 0, 3, T_ACK, 32'h00001234, 0,
                 4, 2'b00, 32'h00001234, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 15'h0048, 32'hDEADBEEF, 4'hC, 1, 4, T_ACK, 32'h0, 2,
                 4, 2'b11, 32'h0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 15'h0050, 32'h0, 4'hF, 1, 0, T_ACKERR, 32'h0000DEAD, 0,
                 1, 2'b00, 32'h0000DEAD, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 15'h0054, 32'h0, 4'hF, 3, 0, T_ERR, 32'hFFFFFFFF, 1,
                 1, 2'b01, 32'h0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 15'h0058, 32'h0, 4'hF, 254, 0, T_ACK, 32'h0000CAFE, 0,
                 1, 2'b00, 32'h0000CAFE, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 15'h005C, 32'h0000BEEF, 4'hF, 0, 1, T_ERR, 32'h0, 0,
                 2, 2'b01, 32'h0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 15'h0060, 32'h0, 4'h8, 2, 2, T_ACK, 32'h87654321, 1,
                 3, 2'b00, 32'h87654321, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_ctrl", {cmd_ready_o, rsp_valid_o, wb_cyc_o, wb_stb_o, wb_we_o, timeout_o, invalid_o}, 7'b0);
    check("rst_data", {wb_adr_o, wb_sel_o, rsp_status_o}, '0);
    check("rst_dat", wb_dat_o | rsp_dat_o, 32'h0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rel_ready", cmd_ready_o, 1'b1);

    // Terminations while idle are ignored
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      check("idle_stray", {wb_cyc_o, rsp_valid_o, timeout_o, invalid_o, cmd_ready_o}, 5'b00001);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during BUS
    drive_cmd("rstbus", 1'b1, 15'h0055, 32'h0000AAAA, 4'hF, ok);
    check("rstbus_cyc", wb_cyc_o, 1'b1);
    repeat (4) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rstbus_out", {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, cmd_ready_o, timeout_o, invalid_o}, 7'b0);
    check("rstbus_adr", 32'(wb_adr_o), 32'h0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rstbus_rel", {cmd_ready_o, rsp_valid_o, wb_cyc_o}, 3'b100);

    // Reset during RESP with rsp_ready_i low, plus stray ERR while in RESP
    drive_cmd("rstrsp", 1'b0, 15'h0066, 32'h0, 4'hF, ok);
    wb_dat_i = 32'h11223344;
    wb_ack_i = 1'b1;
    @(negedge wb_clk_i);
    wb_ack_i = 1'b0;
    check("rstrsp_rsp", {rsp_valid_o, rsp_status_o, wb_cyc_o}, 4'b1000);
    check("rstrsp_dat", rsp_dat_o, 32'h11223344);
    wb_err_i = 1'b1;
    @(negedge wb_clk_i);
    wb_err_i = 1'b0;
    check("resp_stray", {rsp_valid_o, rsp_status_o, invalid_o, wb_cyc_o}, 5'b10000);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rstrsp_out", {rsp_valid_o, cmd_ready_o, wb_cyc_o, rsp_status_o}, 5'b0);
    check("rstrsp_dat0", rsp_dat_o, 32'h0);
    wb_rst_i = 1'b0;
    wait_ready("rstrsp_rel", ok);
    check("rstrsp_nostale", rsp_valid_o, 1'b0);

    run_vec(vecs[0], "recover");
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
